rand_stream_sched: RTL and testbench
====================================

Name: rand_stream_sched

Overview:
- Round-robin scheduler that shares one multi-stream random number generator peripheral between NREQ local requesters.
- Each requester names its own stream number. The scheduler sequences the generator's register interface for that requester: select stream (only when it differs from the last programmed one), settle, read value, advance.
- Sits between client logic (e.g. per-core random sources) and the generator's 32-bit register slave. The generator register map is: 0x0 read value / write advance; 0x4 stream number.

Parameters:
- NREQ, 4, number of requesters (2..16).
- STREAM_W, 10, stream number width.
- SETTLE, 2, idle cycles after a stream write before the value read (covers the generator's registered state-RAM address).
- TIMEOUT, 255, maximum cycles waiting for m_ack_i per bus phase (8-bit counter).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-low.
- req_i  in  NREQ  level request per requester; held until its done_o bit.
- stream_i  in  NREQ*STREAM_W  stream number for requester k in bits [k*STREAM_W +: STREAM_W]; sampled at grant.
- done_o  out  NREQ  one-cycle completion pulse, one-hot.
- dat_o  out  32  random value; valid while any done_o bit is high, otherwise holds last value.
- err_o  out  1  one-cycle pulse with done_o when the operation timed out.
- busy_o  out  1  high in any state other than IDLE.
- m_cyc_o, m_stb_o  out  1  bus cycle/strobe, always driven together.
- m_we_o  out  1  write enable.
- m_adr_o  out  4  byte address (0x0 or 0x4).
- m_dat_o  out  32  write data ({0, stream} for 0x4, 0 for 0x0).
- m_ack_i  in  1  slave acknowledge.
- m_dat_i  in  32  slave read data, valid with m_ack_i.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; all outputs 0.
  - rr_ptr=NREQ-1; stream cache invalid; timeout counter 0.
  - A bus cycle in flight is dropped immediately.
- IDLE:
  - If any req_i is set, pick the first set bit searching from rr_ptr+1 upward, wrapping modulo NREQ.
  - Latch grant index g and stream_i[g]; set rr_ptr=g; go to ARB (one registered cycle).
  - No req_i set: stay in IDLE.
- ARB:
  - Cache valid and latched stream == cached stream: go to RD.
  - Otherwise go to WSTRM.
- Bus phase rule (WSTRM, RD, ADV):
  - Assert cyc/stb/we/adr/dat from the first cycle of the state and hold them stable until the cycle m_ack_i=1.
  - Deassert cyc/stb on the following cycle; there is at least one idle bus cycle between phases.
  - The timeout counter clears on phase entry and increments each un-acked cycle.
  - Counter reaching TIMEOUT: drop cyc/stb, go to DONE with err flag set, invalidate cache.
- WSTRM: write 0x4 with zero-extended stream. On ack, record cached stream=stream, cache valid=1, go to SETTLE.
- SETTLE: count SETTLE cycles with the bus idle, then go to RD. SETTLE=0 skips straight to RD.
- RD: read 0x0. On ack, capture m_dat_i into dat_o, go to ADV.
- ADV: write 0x0 with data 0 (advances the selected stream). On ack, go to DONE.
- DONE (one cycle):
  - done_o[g]=1; err_o=err flag; clear err flag; go to IDLE.
  - On timeout, dat_o holds its previous value.
- Grant and arbitration details:
  - Latency with no stream change and single-cycle acks: IDLE→done_o is 8 cycles. Stream change adds 2+SETTLE cycles.
  - A req_i drop mid-operation does not abort; done_o still pulses.
  - The same requester cannot be regranted in the cycle after its done_o. Re-arbitration happens only in IDLE.
  - The next grant starts after g. With all requests held, service order is strictly rotating.
  - stream_i changes after grant are ignored until the next grant.
  - m_ack_i outside a bus phase is ignored.
- Width rules: stream occupies m_dat_o[STREAM_W-1:0]; upper bits are 0. Cache compare is full STREAM_W bits.

Test Plan:
- After reset, req_i=0001, stream 5, slave acks in 1 cycle and returns 0x12345678 → bus sequence: W 0x4=0x5; 2 idle; R 0x0; W 0x0=0. Then done_o=0001, dat_o=0x12345678, err_o=0.
- Repeat req0 with stream 5 → no 0x4 write; done 8 cycles after request.
- req_i=1111 held, all streams distinct, last grant 0 → grants 1,2,3,0,1. Each performs a 0x4 write; done_o pulses in that order.
- Slave withholds ack on RD → cyc drops after 255 cycles; done_o=0001 with err_o=1; dat_o unchanged. The next req0 with the same stream re-writes 0x4.
- rst_i low during RD with cyc high → cyc/stb/busy_o/done_o go 0 asynchronously. After release, req0 with the same stream performs a 0x4 write (cache invalid).
- Stream 0x3FF, then stream 0x000 from requester 1 → m_dat_o=0x000003FF, then 0x00000000; each triggers a stream write.

Source files
------------

// File: rtl/rand_stream_sched.sv
// Round-robin scheduler sharing one multi-stream RNG register slave among NREQ requesters.
// Per grant: optional stream select (0x4), settle, read value (0x0), advance write (0x0).
module rand_stream_sched #(
  parameter int NREQ     = 4,
  parameter int STREAM_W = 10,
  parameter int SETTLE   = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ*STREAM_W-1:0] stream_i,
  output logic [NREQ-1:0]          done_o,
  output logic [31:0]              dat_o,
  output logic                     err_o,
  output logic                     busy_o,
  output logic                     m_cyc_o,
  output logic                     m_stb_o,
  output logic                     m_we_o,
  output logic [3:0]               m_adr_o,
  output logic [31:0]              m_dat_o,
  input  logic                     m_ack_i,
  input  logic [31:0]              m_dat_i
);

  localparam int IDX_W      = (NREQ > 1) ? $clog2(NREQ) : 1;
  // A zero settle still leaves one idle bus cycle between the stream write and the read.
  localparam int SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
  localparam int SCNT_W     = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;

  localparam logic [7:0]        TMO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SETTLE_EFF - 1);
  localparam logic [IDX_W-1:0]  PTR_RST   = IDX_W'(NREQ - 1);
  localparam logic [NREQ-1:0]   ONE_HOT0  = NREQ'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARB    = 3'd1,
    S_WSTRM  = 3'd2,
    S_SETTLE = 3'd3,
    S_RD     = 3'd4,
    S_ADV    = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t                state_r;
  logic [IDX_W-1:0]      rr_ptr_r;
  logic [IDX_W-1:0]      gnt_r;
  logic [STREAM_W-1:0]   strm_r;
  logic [STREAM_W-1:0]   cache_r;
  logic                  cache_vld_r;
  logic [7:0]            tmo_r;
  logic [SCNT_W-1:0]     scnt_r;
  logic                  ph_done_r;
  logic [NREQ-1:0]       done_r;
  logic [31:0]           dat_r;
  logic                  err_r;
  logic                  busy_r;
  logic                  cyc_r;
  logic                  we_r;
  logic [3:0]            adr_r;
  logic [31:0]           wdat_r;

  logic                  gnt_vld_s;
  logic [IDX_W-1:0]      gnt_idx_s;
  logic [STREAM_W-1:0]   gnt_strm_s;
  logic [NREQ-1:0]       gnt_mask_s;
  logic                  tmo_hit_s;

  // Rotating priority search starting just after the last grant.
  always_comb begin : arb_comb
    int               sum;
    logic [IDX_W-1:0] idx;
    logic             hit;
    gnt_vld_s = 1'b0;
    gnt_idx_s = '0;
    sum       = 0;
    idx       = '0;
    hit       = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      sum       = int'(rr_ptr_r) + i;
      sum       = (sum >= NREQ) ? (sum - NREQ) : sum;
      idx       = IDX_W'(sum);
      hit       = req_i[idx] && !gnt_vld_s;
      gnt_idx_s = hit ? idx : gnt_idx_s;
      gnt_vld_s = gnt_vld_s | hit;
    end
  end

  assign gnt_strm_s = stream_i[gnt_idx_s*STREAM_W +: STREAM_W];
  assign gnt_mask_s = ONE_HOT0 << gnt_r;
  assign tmo_hit_s  = (tmo_r == TMO_LAST);

  assign done_o  = done_r;
  assign dat_o   = dat_r;
  assign err_o   = err_r;
  assign busy_o  = busy_r;
  assign m_cyc_o = cyc_r;
  assign m_stb_o = cyc_r;
  assign m_we_o  = we_r;
  assign m_adr_o = adr_r;
  assign m_dat_o = wdat_r;

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r     <= S_IDLE;
      rr_ptr_r    <= PTR_RST;
      gnt_r       <= '0;
      strm_r      <= '0;
      cache_r     <= '0;
      cache_vld_r <= 1'b0;
      tmo_r       <= 8'd0;
      scnt_r      <= '0;
      ph_done_r   <= 1'b0;
      done_r      <= '0;
      dat_r       <= 32'd0;
      err_r       <= 1'b0;
      busy_r      <= 1'b0;
      cyc_r       <= 1'b0;
      we_r        <= 1'b0;
      adr_r       <= 4'h0;
      wdat_r      <= 32'd0;
    end else begin
      done_r <= '0;
      err_r  <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (gnt_vld_s) begin
            gnt_r    <= gnt_idx_s;
            rr_ptr_r <= gnt_idx_s;
            strm_r   <= gnt_strm_s;
            busy_r   <= 1'b1;
            state_r  <= S_ARB;
          end else begin
            state_r  <= S_IDLE;
          end
        end
        S_ARB: begin
          tmo_r <= 8'd0;
          cyc_r <= 1'b1;
          if (cache_vld_r && (strm_r == cache_r)) begin
            we_r    <= 1'b0;
            adr_r   <= 4'h0;
            wdat_r  <= 32'd0;
            state_r <= S_RD;
          end else begin
            we_r    <= 1'b1;
            adr_r   <= 4'h4;
            wdat_r  <= 32'(strm_r);
            state_r <= S_WSTRM;
          end
        end
        S_WSTRM: begin
          if (m_ack_i) begin
            cyc_r       <= 1'b0;
            we_r        <= 1'b0;
            adr_r       <= 4'h0;
            wdat_r      <= 32'd0;
            cache_r     <= strm_r;
            cache_vld_r <= 1'b1;
            scnt_r      <= '0;
            state_r     <= S_SETTLE;
          end else if (tmo_hit_s) begin
            cyc_r       <= 1'b0;
            we_r        <= 1'b0;
            adr_r       <= 4'h0;
            wdat_r      <= 32'd0;
            cache_vld_r <= 1'b0;
            done_r      <= gnt_mask_s;
            err_r       <= 1'b1;
            state_r     <= S_DONE;
          end else begin
            tmo_r       <= tmo_r + 8'd1;
          end
        end
        S_SETTLE: begin
          if (scnt_r == SCNT_LAST) begin
            tmo_r   <= 8'd0;
            cyc_r   <= 1'b1;
            we_r    <= 1'b0;
            adr_r   <= 4'h0;
            wdat_r  <= 32'd0;
            state_r <= S_RD;
          end else begin
            scnt_r  <= scnt_r + SCNT_W'(1);
          end
        end
        S_RD: begin
          // ph_done_r marks the idle bus cycle that separates read and advance.
          if (ph_done_r) begin
            ph_done_r <= 1'b0;
            tmo_r     <= 8'd0;
            cyc_r     <= 1'b1;
            we_r      <= 1'b1;
            adr_r     <= 4'h0;
            wdat_r    <= 32'd0;
            state_r   <= S_ADV;
          end else if (m_ack_i) begin
            dat_r     <= m_dat_i;
            cyc_r     <= 1'b0;
            ph_done_r <= 1'b1;
          end else if (tmo_hit_s) begin
            cyc_r       <= 1'b0;
            cache_vld_r <= 1'b0;
            done_r      <= gnt_mask_s;
            err_r       <= 1'b1;
            state_r     <= S_DONE;
          end else begin
            tmo_r       <= tmo_r + 8'd1;
          end
        end
        S_ADV: begin
          if (ph_done_r) begin
            ph_done_r <= 1'b0;
            done_r    <= gnt_mask_s;
            state_r   <= S_DONE;
          end else if (m_ack_i) begin
            cyc_r     <= 1'b0;
            we_r      <= 1'b0;
            ph_done_r <= 1'b1;
          end else if (tmo_hit_s) begin
            cyc_r       <= 1'b0;
            we_r        <= 1'b0;
            cache_vld_r <= 1'b0;
            done_r      <= gnt_mask_s;
            err_r       <= 1'b1;
            state_r     <= S_DONE;
          end else begin
            tmo_r       <= tmo_r + 8'd1;
          end
        end
        S_DONE: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          cyc_r     <= 1'b0;
          we_r      <= 1'b0;
          ph_done_r <= 1'b0;
          busy_r    <= 1'b0;
          state_r   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rand_stream_sched.sv
// Randomised and directed bench for rand_stream_sched: a bus slave model logs every
// acknowledged transfer and a transaction-level model predicts the expected sequence.
module tb_rand_stream_sched;

  localparam int NREQ     = 4;
  localparam int STREAM_W = 10;
  localparam int SETTLE   = 2;
  localparam int TIMEOUT  = 255;

  logic                     clk_i = 1'b0;
  logic                     rst_i = 1'b0;
  logic [NREQ-1:0]          req_i = '0;
  logic [NREQ*STREAM_W-1:0] stream_i = '0;
  logic [NREQ-1:0]          done_o;
  logic [31:0]              dat_o;
  logic                     err_o;
  logic                     busy_o;
  logic                     m_cyc_o;
  logic                     m_stb_o;
  logic                     m_we_o;
  logic [3:0]               m_adr_o;
  logic [31:0]              m_dat_o;
  logic                     m_ack_i;
  logic [31:0]              m_dat_i;

  rand_stream_sched #(
    .NREQ(NREQ), .STREAM_W(STREAM_W), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .stream_i(stream_i),
    .done_o(done_o), .dat_o(dat_o), .err_o(err_o), .busy_o(busy_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_adr_o(m_adr_o),
    .m_dat_o(m_dat_o), .m_ack_i(m_ack_i), .m_dat_i(m_dat_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [3:0]  adr;
    logic [31:0] dat;
    int          start;
    int          ackc;
  } txn_t;

  txn_t        log_q[$];
  logic        ack_r = 1'b0;
  logic [31:0] rdata_v = 32'd0;
  bit          block_rd = 1'b0;
  int          cyc_n = 0;
  int          cur_start = 0;
  int          run_len = 0;
  int          last_run = 0;
  int          gap_err = 0;
  int          stab_err = 0;
  logic        prev_cyc = 1'b0;
  logic        prev_acked = 1'b0;
  logic [36:0] held = '0;

  assign m_ack_i = ack_r;
  assign m_dat_i = rdata_v;

  // Slave model: registered one-cycle ack, transfer log, gap and stability monitors.
  always @(posedge clk_i) begin
    cyc_n <= cyc_n + 1;
    if (m_cyc_o && !prev_cyc) begin
      cur_start <= cyc_n;
      held      <= {m_we_o, m_adr_o, m_dat_o};
    end else if (m_cyc_o && (held !== {m_we_o, m_adr_o, m_dat_o})) begin
      stab_err <= stab_err + 1;
    end
    if (m_cyc_o && prev_acked) gap_err <= gap_err + 1;
    if (m_cyc_o !== m_stb_o) stab_err <= stab_err + 1;
    if (m_cyc_o && m_ack_i) log_q.push_back('{m_we_o, m_adr_o, m_dat_o, cur_start, cyc_n});
    if (m_cyc_o) begin
      run_len <= run_len + 1;
    end else begin
      if (run_len != 0) last_run <= run_len;
      run_len <= 0;
    end
    ack_r      <= m_cyc_o && !m_ack_i && !(block_rd && !m_we_o);
    prev_cyc   <= m_cyc_o;
    prev_acked <= m_cyc_o && m_ack_i;
  end

  int          total = 0;
  int          bad = 0;
  int          last_g = NREQ - 1;
  int          cache_s = -1;
  logic [31:0] last_dat = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int next_grant(input logic [NREQ-1:0] req, input int last);
    for (int i = 1; i <= NREQ; i++)
      if (req[(last + i) % NREQ]) return (last + i) % NREQ;
    return -1;
  endfunction

  // One complete single-requester operation checked against the model.
  task automatic run_op(input int k, input logic [STREAM_W-1:0] s, input logic [31:0] rd, input bit tmo);
    bit wr;
    int lat, rd_start, n_exp, ri;
    wr = (cache_s != int'(s));
    rd_start = wr ? (2 + 2 + SETTLE) : 2;
    n_exp = (wr ? 1 : 0) + (tmo ? 0 : 2);
    log_q.delete();
    rdata_v = rd;
    stream_i[k*STREAM_W +: STREAM_W] = s;
    req_i[k] = 1'b1;
    lat = 0;
    do begin
      @(negedge clk_i);
      lat++;
    end while (done_o == '0 && lat < 600);
    req_i[k] = 1'b0;
    if (!tmo) last_dat = rd;
    chk("done_onehot", done_o, 32'(1) << k);
    chk("err", err_o, tmo);
    chk("dat", dat_o, last_dat);
    chk("latency", lat, tmo ? (rd_start + TIMEOUT) : (rd_start + 6));
    @(negedge clk_i);
    chk("busy_after", busy_o, 1'b0);
    chk("ntxn", log_q.size(), n_exp);
    if (log_q.size() == n_exp) begin
      ri = 0;
      if (wr) begin
        chk("wstrm_we", log_q[0].we, 1'b1);
        chk("wstrm_adr", log_q[0].adr, 4'h4);
        chk("wstrm_dat", log_q[0].dat, 32'(s));
        ri = 1;
      end
      if (!tmo) begin
        chk("rd_we", log_q[ri].we, 1'b0);
        chk("rd_adr", log_q[ri].adr, 4'h0);
        if (wr) chk("settle_gap", log_q[ri].start - log_q[0].ackc - 1, SETTLE);
        chk("adv_we", log_q[ri+1].we, 1'b1);
        chk("adv_adr", log_q[ri+1].adr, 4'h0);
        chk("adv_dat", log_q[ri+1].dat, 32'd0);
      end
    end
    cache_s = tmo ? -1 : int'(s);
    last_g = k;
  endtask

  initial begin
    int lat, g, waitc;
    logic [31:0] rd;
    // Reset state.
    repeat (3) @(negedge clk_i);
    chk("rst_cyc", m_cyc_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, '0);
    chk("rst_dat", dat_o, 32'd0);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("post_rst_err", err_o, 1'b0);

    // Stream write, settle, read, advance; then cached stream.
    run_op(0, 10'd5, 32'h12345678, 1'b0);
    run_op(0, 10'd5, $urandom, 1'b0);

    // All requesters held: strictly rotating service order.
    for (int k = 0; k < NREQ; k++) stream_i[k*STREAM_W +: STREAM_W] = 10'(32'h100 + k);
    req_i = '1;
    for (int n = 0; n < 5; n++) begin
      log_q.delete();
      rd = $urandom;
      rdata_v = rd;
      g = next_grant(req_i, last_g);
      lat = 0;
      do begin
        @(negedge clk_i);
        lat++;
      end while (done_o == '0 && lat < 100);
      if (n == 4) req_i = '0;
      chk("rr_grant", done_o, 32'(1) << g);
      chk("rr_dat", dat_o, rd);
      chk("rr_ntxn", log_q.size(), 3);
      if (log_q.size() == 3) chk("rr_wstrm", log_q[0].dat, 32'h100 + g);
      last_g = g;
      cache_s = 32'h100 + g;
      last_dat = rd;
    end
    @(negedge clk_i);

    // Read phase timeout, then cache must be invalid.
    run_op(0, 10'd5, $urandom, 1'b0);
    block_rd = 1'b1;
    run_op(0, 10'd5, 32'hDEADBEEF, 1'b1);
    chk("tmo_cyc_len", last_run, TIMEOUT);
    block_rd = 1'b0;
    run_op(0, 10'd5, $urandom, 1'b0);

    // Asynchronous reset in the middle of the read phase.
    req_i[0] = 1'b1;
    waitc = 0;
    while (!(m_cyc_o && !m_we_o) && waitc < 50) begin
      @(negedge clk_i);
      waitc++;
    end
    chk("rd_reached", m_cyc_o && !m_we_o, 1'b1);
    #2 rst_i = 1'b0;
    #1;
    chk("arst_cyc", m_cyc_o, 1'b0);
    chk("arst_stb", m_stb_o, 1'b0);
    chk("arst_busy", busy_o, 1'b0);
    chk("arst_done", done_o, '0);
    req_i = '0;
    @(negedge clk_i);
    rst_i = 1'b1;
    cache_s = -1;
    last_g = NREQ - 1;
    last_dat = 32'd0;
    @(negedge clk_i);
    run_op(0, 10'd5, $urandom, 1'b0);

    // Stream width extremes.
    run_op(0, 10'h3FF, $urandom, 1'b0);
    run_op(1, 10'h000, $urandom, 1'b0);

    // Random single requests over a small stream pool.
    for (int n = 0; n < 16; n++)
      run_op($urandom_range(0, NREQ - 1), 10'($urandom_range(1, 3)), $urandom, 1'b0);

    chk("gap_violations", gap_err, 0);
    chk("stability_violations", stab_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
